port_uart_tx: RTL and testbench
===============================

Name: port_uart_tx

Overview:
- Serial transmitter that sits directly downstream of the YASAC processor's output ports.
- The program writes a byte to output port 00, then toggles port 01 bit 0 to queue it.
- Bytes are buffered in a small FIFO and sent as 8N1 UART frames on txd.
- A status byte is returned to input port 08 so software can poll full, busy and overflow.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  byte to queue; connected to port00
- req_tog  input  1  queue request; any change of level is one request; connected to port01[0]
- clr_tog  input  1  overflow-clear request; any change of level clears; connected to port01[1]
- status  output  8  to port08: [0] full, [1] busy, [2] ovf (sticky), [7:3] = 0
- txd  output  1  serial line; idle high

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset:
  - txd=1, FSM=IDLE, FIFO empty (count 0), ovf=0, baud and bit counters 0.
  - req_q<=req_tog and clr_q<=clr_tog, so a level present during reset never creates a request.
  - status=8'h00 on the cycle after reset.
- Toggle detect:
  - push_ev = req_tog != req_q; clr_ev = clr_tog != clr_q.
  - req_q and clr_q update every cycle.
  - Held levels never repeat a request.
- Push:
  - On push_ev with count < depth, data_in is sampled on that same edge and written at the write pointer.
  - If count == depth (evaluated before any same-cycle pop), the byte is dropped and ovf is set to 1.
  - A simultaneous pop does not make room for that push.
  - Pointers wrap modulo depth.
- ovf: cleared by clr_ev; if clr_ev and an overflowing push occur in the same cycle, ovf ends at 1 (set wins).
- FIFO count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states:
  - IDLE: txd=1. If count != 0, pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] (LSB first) for CLK_DIV cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLK_DIV cycles, then go to IDLE.
- Timing:
  - A frame is 10*CLK_DIV cycles plus 1 IDLE cycle between back-to-back frames.
  - If push_ev is seen on edge E (FIFO empty, IDLE), the pop happens on edge E+1 and txd first reads 0 after edge E+2.
- Baud counter: counts 0..CLK_DIV-1; a bit period ends when it reaches CLK_DIV-1, then it reloads to 0.
- status:
  - full = (count == depth).
  - busy = (FSM != IDLE) or (count != 0).
  - Both derived from registers only; no combinational path from inputs.
- txd is registered (glitch-free).
- Reset mid-frame: the frame is aborted, txd=1 after that edge, and queued bytes are discarded.

Test Plan:
- CLK_DIV=4. Reset, data_in=8'h55, toggle req_tog once -> txd low after edge E+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles. busy=1 from E+1 until the frame ends, then busy=0. Exactly one frame.
- Toggle req_tog every 2 cycles with bytes 8'h01..8'h06 -> 8'h01 popped at once, 8'h02..8'h05 fill the FIFO (full=1), 8'h06 dropped with ovf=1. Five frames 01..05 emitted in order, each 41 cycles apart.
- After the previous test, toggle clr_tog -> status[2]=0 next cycle; full clears once the first queued byte pops.
- Hold req_tog=1 through reset, then leave it static for 100 cycles -> no push, txd stays 1, status=8'h00.
- Queue 8'hA3, assert reset for 1 cycle during DATA bit 3 -> txd=1 the cycle after reset and stays 1; status=8'h00; no further frame.
- Queue 8'hFF and 8'h00 back-to-back with CLK_DIV=2 -> two frames: first start,FFx8,stop; 1 idle cycle; then start,00x8,stop.

Source files
------------

// File: rtl/port_uart_tx.sv
// port_uart_tx: byte FIFO plus 8N1 UART transmitter fed from processor output
// ports. A byte is queued by toggling req_tog, and a sticky overflow flag is
// cleared by toggling clr_tog. A status byte (full, busy, ovf) is returned
// for software to poll.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | line high; pop the FIFO head when one is queued
// START   | start bit (low) for one bit period
// DATA    | eight data bits, LSB first
// STOP    | stop bit (high) for one bit period
module port_uart_tx #(
  parameter int CLK_DIV = 16,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       req_tog,
  input  logic       clr_tog,
  output logic [7:0] status,
  output logic       txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [15:0]        BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e             state_q;
  logic               req_q;
  logic               clr_q;
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               ovf_q;
  logic [7:0]         shift_q;
  logic [15:0]        baud_q;
  logic [2:0]         bit_q;
  logic               txd_q;
  logic               txd_d;

  logic push_ev;
  logic clr_ev;
  logic full;
  logic push_ok;
  logic pop;
  logic baud_end;
  logic busy;

  assign push_ev  = req_tog ^ req_q;
  assign clr_ev   = clr_tog ^ clr_q;
  assign full     = (count_q == DEPTH_C);
  // Fullness is judged before any same-cycle pop, so a pop never makes room
  // for a push arriving on the same edge.
  assign push_ok  = push_ev && !full;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);
  assign baud_end = (baud_q == BAUD_LAST);
  assign busy     = (state_q != ST_IDLE) || (count_q != '0);

  assign status = {5'b0_0000, ovf_q, busy, full};
  assign txd    = txd_q;

  // Line level implied by the current state; registered below so txd lags
  // the state by one cycle and never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_IDLE:  txd_d = 1'b1;
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      ST_STOP:  txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Toggle detection, FIFO bookkeeping, overflow flag and transmit FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= req_tog;
      clr_q    <= clr_tog;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
    end else begin
      req_q <= req_tog;
      clr_q <= clr_tog;
      txd_q <= txd_d;

      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end

      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      // Set wins over a same-cycle clear.
      if (push_ev && full) begin
        ovf_q <= 1'b1;
      end else if (clr_ev) begin
        ovf_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            baud_q   <= '0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a CLK_DIV=4 instance for most scenarios and a
// CLK_DIV=2 instance for the back-to-back frame case. Frames are checked
// against hand-computed 10-bit patterns (bit i = i-th bit on the line).
module tb_port_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data4, data2;
  logic       req4, req2, clr4, clr2;
  logic [7:0] status4, status2;
  logic       txd4, txd2;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  port_uart_tx #(.CLK_DIV(4), .FIFO_AW(2)) u4 (
    .clk(clk), .reset(reset), .data_in(data4), .req_tog(req4),
    .clr_tog(clr4), .status(status4), .txd(txd4)
  );

  port_uart_tx #(.CLK_DIV(2), .FIFO_AW(2)) u2 (
    .clk(clk), .reset(reset), .data_in(data2), .req_tog(req2),
    .clr_tog(clr2), .status(status2), .txd(txd2)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic txd_of(input int sel);
    return (sel != 0) ? txd2 : txd4;
  endfunction

  // Advance until the selected line goes low; report the cycle it was seen.
  task automatic wait_start(input int sel, input int budget, output int start_cyc);
    int n;
    n = 0;
    while (txd_of(sel) !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", {31'd0, txd_of(sel) === 1'b0}, 32'd1);
    start_cyc = cyc;
  endtask

  // Called while the first start-bit cycle is being sampled.
  task automatic check_frame(input int sel, input int idx, input int div);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < div; c++) begin
        if (i != 0 || c != 0) tick();
        check($sformatf("frame%0d_bit%0d_c%0d", idx, i, c),
              {31'd0, txd_of(sel)}, {31'd0, tbl[idx].frame[i]});
      end
    end
  endtask

  task automatic quiet4(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (txd4 !== 1'b1 || status4 !== 8'h00) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, p1;

    tbl[0] = '{8'h55, 10'h2AA};
    tbl[1] = '{8'h01, 10'h202};
    tbl[2] = '{8'h02, 10'h204};
    tbl[3] = '{8'h03, 10'h206};
    tbl[4] = '{8'h04, 10'h208};
    tbl[5] = '{8'h05, 10'h20A};
    tbl[6] = '{8'hFF, 10'h3FE};
    tbl[7] = '{8'h00, 10'h200};

    reset = 1'b1;
    data4 = 8'h00; data2 = 8'h00;
    req4 = 1'b0; req2 = 1'b0; clr4 = 1'b0; clr2 = 1'b0;
    @(negedge clk);
    tick();
    check("reset_status4", status4, 8'h00);
    check("reset_txd4", txd4, 1'b1);
    check("reset_status2", status2, 8'h00);
    check("reset_txd2", txd2, 1'b1);
    reset = 1'b0;
    tick();

    // Single frame 0x55 with exact start latency.
    data4 = tbl[0].data;
    req4  = ~req4;
    tick();                              // edge E: push
    tick();                              // edge E+1: pop
    check("lat_txd_e1", txd4, 1'b1);
    check("lat_busy_e1", status4, 8'h02);
    tick();                              // edge E+2: start bit visible
    check_frame(0, 0, 4);
    check("frame0_done_status", status4, 8'h00);
    quiet4("single_frame_only", 60);

    // Burst of six toggles: 01 pops at once, 02..05 fill, 06 overflows.
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          data4 = (k <= 5) ? tbl[k].data : 8'h06;
          req4  = ~req4;
          tick();
          if (k == 1) p1 = cyc;
          tick();
        end
        check("burst_full_ovf", status4, 8'h07);
        clr4 = ~clr4;
        tick();
        check("clr_ovf", status4, 8'h03);
        while (cyc < p1 + 41) tick();
        check("still_full_before_pop", status4, 8'h03);
        tick();
        check("full_cleared_after_pop", status4, 8'h02);
      end
      begin
        s0 = 0;
        for (int f = 1; f <= 5; f++) begin
          wait_start(0, 200, s1);
          if (f > 1) check($sformatf("spacing%0d", f), s1 - s0, 41);
          s0 = s1;
          check_frame(0, f, 4);
        end
      end
    join
    tick();
    check("burst_done_status", status4, 8'h00);
    quiet4("no_sixth_frame", 60);

    // Level changing while in reset must not create a request afterwards.
    reset = 1'b1;
    req4  = 1'b0;
    tick();
    req4  = 1'b1;
    tick();
    reset = 1'b0;
    quiet4("held_req_no_push", 100);

    // Reset during data bit 3 of 0xA3 with a second byte queued.
    data4 = 8'hA3;
    req4  = ~req4;
    tick();
    data4 = 8'h5A;
    req4  = ~req4;
    tick();                              // simultaneous push and pop
    check("push_pop_same_cycle", status4, 8'h02);
    wait_start(0, 20, s1);
    for (int k = 0; k < 17; k++) tick();
    check("a3_bit3_low", txd4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_txd", txd4, 1'b1);
    check("abort_status", status4, 8'h00);
    quiet4("abort_no_frame", 80);

    // Back-to-back frames at CLK_DIV=2.
    data2 = tbl[6].data;
    req2  = ~req2;
    tick();
    data2 = tbl[7].data;
    req2  = ~req2;
    tick();
    wait_start(1, 20, s0);
    check_frame(1, 6, 2);
    tick();
    check("b2b_idle_gap", txd2, 1'b1);
    wait_start(1, 20, s1);
    check("b2b_spacing", s1 - s0, 21);
    check_frame(1, 7, 2);
    tick();
    tick();
    check("b2b_done_status", status2, 8'h00);
    check("b2b_done_txd", txd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
